// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters are enabled with `define PIPE_HAZARD_PERF_CNT_EN.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } hz_state_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the pipeline datapath (master) and the hazard controller (slave).
// Handshake: MemReqM is held while a load/store sits in M; MemAckM completes it in that cycle.
interface pipe_hazard_ctrl_if;

   logic [4:0]  Rs1D, Rs2D;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic [1:0]  ResultSrcE;
   logic        PCSrcE;
   logic [4:0]  RdM, RdW;
   logic        RegWriteM, RegWriteW;
   logic        MemAccessM;
   logic        MemAckM;
   logic        MemReqM;
   logic        StallF, StallD, StallE, StallM;
   logic        FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        MemErr;
   logic [31:0] StallCycles, FlushCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
      output RdM, RdW, RegWriteM, RegWriteW, MemAccessM, MemAckM,
      input  MemReqM, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
      input  MemErr, StallCycles, FlushCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
      input  RdM, RdW, RegWriteM, RegWriteW, MemAccessM, MemAckM,
      output MemReqM, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
      output MemErr, StallCycles, FlushCount
   );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Single E-stage operand forwarding compare; the younger M result beats W.
module pipe_fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs_e,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
         fwd = FWD_M;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
         fwd = FWD_W;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding and the M-stage memory FSM.
// `define PIPE_HAZARD_PERF_CNT_EN adds the StallCycles/FlushCount counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   pipe_hazard_ctrl_if.slave hz,
   output hz_state_t        dbg_state,
   output logic [CNT_W-1:0] dbg_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   hz_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             mem_err;

   logic mem_req, mem_stall, lw_stall;
   logic req_o, stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_w;
   logic [1:0] fwd_a, fwd_b, fwd_a_o, fwd_b_o;

   pipe_fwd_unit u_fwd_a (
      .rs_e        (hz.Rs1E),
      .rd_m        (hz.RdM),
      .rd_w        (hz.RdW),
      .reg_write_m (hz.RegWriteM),
      .reg_write_w (hz.RegWriteW),
      .fwd         (fwd_a)
   );

   pipe_fwd_unit u_fwd_b (
      .rs_e        (hz.Rs2E),
      .rd_m        (hz.RdM),
      .rd_w        (hz.RdW),
      .reg_write_m (hz.RegWriteM),
      .reg_write_w (hz.RegWriteW),
      .fwd         (fwd_b)
   );

   assign mem_req   = hz.MemAccessM & (state != ERR);
   assign mem_stall = mem_req & ~hz.MemAckM;
   assign lw_stall  = (hz.ResultSrcE == RESULT_SRC_LOAD) & (hz.RdE != 5'd0) &
                      ((hz.Rs1D == hz.RdE) | (hz.Rs2D == hz.RdE));

   // Memory stall freezes everything; a pending branch/load-use re-evaluates after release.
   always_comb begin
      req_o   = 1'b0;
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      fwd_a_o = fwd_a;
      fwd_b_o = fwd_b;
      if (reset) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_w = 1'b1;
         fwd_a_o = FWD_RF;
         fwd_b_o = FWD_RF;
      end else if (state == ERR || mem_stall) begin
         req_o   = mem_req;
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else begin
         req_o   = mem_req;
         stall_f = lw_stall;
         stall_d = lw_stall;
         flush_d = hz.PCSrcE;
         flush_e = hz.PCSrcE | lw_stall;
      end
   end

   // ERR is terminal: only reset leaves it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_stall) begin
                  state <= WAIT;
                  cnt   <= CNT_W'(1);
               end
            end
            WAIT: begin
               if (hz.MemAckM) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= ERR;
                  mem_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_f | stall_d | stall_e | stall_m)
            stall_cycles <= stall_cycles + 32'd1;
         if (flush_d | flush_e)
            flush_count <= flush_count + 32'd1;
      end
   end

   assign hz.StallCycles = stall_cycles;
   assign hz.FlushCount  = flush_count;
`else
   assign hz.StallCycles = '0;
   assign hz.FlushCount  = '0;
`endif

   assign hz.MemReqM   = req_o;
   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.StallM    = stall_m;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushW    = flush_w;
   assign hz.ForwardAE = fwd_a_o;
   assign hz.ForwardBE = fwd_b_o;
   assign hz.MemErr    = mem_err;

   assign dbg_state = state;
   assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl against a behavioural model.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int T = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz_bus ();
   hz_state_t  dbg_state;
   logic [7:0] dbg_cnt;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .hz        (hz_bus),
      .dbg_state (dbg_state),
      .dbg_cnt   (dbg_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // model: memory access outstanding, cycles waited so far, sticky error
   bit          m_wait, m_err;
   int          m_waited;
   logic [31:0] m_stalls, m_flushes;

   logic       e_req, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
   logic [1:0] e_fa, e_fb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (hz_bus.RegWriteM && hz_bus.RdM != 0 && hz_bus.RdM == rs) return 2'b10;
      if (hz_bus.RegWriteW && hz_bus.RdW != 0 && hz_bus.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic predict();
      bit ms, ls;
      ls = (hz_bus.ResultSrcE == 2'b01) && (hz_bus.RdE != 0) &&
           (hz_bus.Rs1D == hz_bus.RdE || hz_bus.Rs2D == hz_bus.RdE);
      ms = hz_bus.MemAccessM && !m_err && !hz_bus.MemAckM;
      e_req = hz_bus.MemAccessM && !m_err;
      e_fa = ref_fwd(hz_bus.Rs1E);
      e_fb = ref_fwd(hz_bus.Rs2E);
      if (reset) begin
         e_req = 0; {e_sf, e_sd, e_se, e_sm} = 4'b0000; {e_fd, e_fe, e_fw} = 3'b111;
         e_fa = 2'b00; e_fb = 2'b00;
      end else if (m_err || ms) begin
         {e_sf, e_sd, e_se, e_sm} = 4'b1111; {e_fd, e_fe, e_fw} = 3'b001;
      end else begin
         e_sf = ls; e_sd = ls; e_se = 0; e_sm = 0;
         e_fd = hz_bus.PCSrcE; e_fe = hz_bus.PCSrcE || ls; e_fw = 0;
      end
   endtask

   task automatic compare_all();
      hz_state_t exp_state;
      predict();
      check("MemReqM", hz_bus.MemReqM, e_req);
      check("StallF", hz_bus.StallF, e_sf);
      check("StallD", hz_bus.StallD, e_sd);
      check("StallE", hz_bus.StallE, e_se);
      check("StallM", hz_bus.StallM, e_sm);
      check("FlushD", hz_bus.FlushD, e_fd);
      check("FlushE", hz_bus.FlushE, e_fe);
      check("FlushW", hz_bus.FlushW, e_fw);
      check("ForwardAE", hz_bus.ForwardAE, e_fa);
      check("ForwardBE", hz_bus.ForwardBE, e_fb);
      check("MemErr", hz_bus.MemErr, m_err);
      exp_state = m_err ? ERR : (m_wait ? WAIT : IDLE);
      check("state", dbg_state, exp_state);
      if (!m_err) check("wait_cnt", dbg_cnt, m_waited);
`ifdef PIPE_HAZARD_PERF_CNT_EN
      check("StallCycles", hz_bus.StallCycles, m_stalls);
      check("FlushCount", hz_bus.FlushCount, m_flushes);
`else
      check("StallCycles", hz_bus.StallCycles, 0);
      check("FlushCount", hz_bus.FlushCount, 0);
`endif
   endtask

   task automatic advance();
      if (reset) begin
         m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         if (e_sf || e_sd || e_se || e_sm) m_stalls = m_stalls + 1;
         if (e_fd || e_fe) m_flushes = m_flushes + 1;
         if (!m_err) begin
            if (!m_wait) begin
               if (e_req && !hz_bus.MemAckM) begin m_wait = 1; m_waited = 1; end
            end else if (hz_bus.MemAckM) begin
               m_wait = 0; m_waited = 0;
            end else if (m_waited == T - 1) begin
               m_err = 1; m_wait = 0;
            end else begin
               m_waited++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
   endtask

   task automatic step();
      cycle();
      advance();
   endtask

   task automatic clear_inputs();
      hz_bus.Rs1D = 0; hz_bus.Rs2D = 0; hz_bus.Rs1E = 0; hz_bus.Rs2E = 0; hz_bus.RdE = 0;
      hz_bus.ResultSrcE = 0; hz_bus.PCSrcE = 0; hz_bus.RdM = 0; hz_bus.RdW = 0;
      hz_bus.RegWriteM = 0; hz_bus.RegWriteW = 0; hz_bus.MemAccessM = 0; hz_bus.MemAckM = 0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;

      cycle();
      check("rst_flushD", hz_bus.FlushD, 1'b1);
      check("rst_stallF", hz_bus.StallF, 1'b0);
      advance();
      reset = 1'b0;

      // load-use: one bubble, then W forwarding
      hz_bus.ResultSrcE = 2'b01; hz_bus.RdE = 5; hz_bus.Rs1D = 5; hz_bus.Rs2D = 7;
      cycle();
      check("lu_stallF", hz_bus.StallF, 1'b1);
      check("lu_flushE", hz_bus.FlushE, 1'b1);
      advance();
      hz_bus.ResultSrcE = 0; hz_bus.RdE = 0; hz_bus.RdM = 5; hz_bus.RegWriteM = 1;
      cycle();
      check("lu_release", hz_bus.StallF, 1'b0);
      advance();
      hz_bus.RdM = 0; hz_bus.RegWriteM = 0; hz_bus.RdW = 5; hz_bus.RegWriteW = 1; hz_bus.Rs1E = 5;
      cycle();
      check("lu_fwdW", hz_bus.ForwardAE, 2'b01);
      advance();

      // M beats W; RdM = x0 never forwards
      clear_inputs();
      hz_bus.RegWriteM = 1; hz_bus.RdM = 3; hz_bus.RegWriteW = 1; hz_bus.RdW = 3;
      hz_bus.Rs1E = 3; hz_bus.Rs2E = 3;
      cycle();
      check("fwd_MoverW", hz_bus.ForwardAE, 2'b10);
      check("fwdB_MoverW", hz_bus.ForwardBE, 2'b10);
      advance();
      hz_bus.RdM = 0;
      cycle();
      check("fwd_x0", hz_bus.ForwardAE, 2'b01);
      advance();

      // 3 wait cycles with a pending branch, released on ack
      clear_inputs();
      hz_bus.MemAccessM = 1; hz_bus.PCSrcE = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("mw_stallM", hz_bus.StallM, 1'b1);
         check("mw_flushW", hz_bus.FlushW, 1'b1);
         check("mw_flushD", hz_bus.FlushD, 1'b0);
         advance();
      end
      hz_bus.MemAckM = 1;
      cycle();
      check("mw_rel_stallF", hz_bus.StallF, 1'b0);
      check("mw_rel_flushD", hz_bus.FlushD, 1'b1);
      check("mw_rel_flushE", hz_bus.FlushE, 1'b1);
      advance();
      clear_inputs();
      cycle();
      check("mw_idle", dbg_state, IDLE);
      advance();

      // timeout into ERR, then reset
      hz_bus.MemAccessM = 1;
      for (int i = 0; i < T; i++) begin
         cycle();
         check("to_stallE", hz_bus.StallE, 1'b1);
         advance();
      end
      cycle();
      check("to_state", dbg_state, ERR);
      check("to_memerr", hz_bus.MemErr, 1'b1);
      check("to_req", hz_bus.MemReqM, 1'b0);
      advance();
      hz_bus.MemAccessM = 0; hz_bus.PCSrcE = 1;
      step();
      step();
      reset = 1'b1;
      cycle();
      check("to_rst_flushD", hz_bus.FlushD, 1'b1);
      advance();
      reset = 1'b0;
      clear_inputs();
      cycle();
      check("to_rst_state", dbg_state, IDLE);
      check("to_rst_memerr", hz_bus.MemErr, 1'b0);
      advance();

      // reset in the middle of a wait
      hz_bus.MemAccessM = 1;
      step();
      step();
      reset = 1'b1;
      cycle();
      check("rw_stallF", hz_bus.StallF, 1'b0);
      check("rw_req", hz_bus.MemReqM, 1'b0);
      advance();
      cycle();
      check("rw_state", dbg_state, IDLE);
      check("rw_cnt", dbg_cnt, 8'd0);
      check("rw_stallcyc", hz_bus.StallCycles, 32'd0);
      advance();
      reset = 1'b0;
      clear_inputs();

      // two load-use stalls and one taken branch
      hz_bus.ResultSrcE = 2'b01; hz_bus.RdE = 2; hz_bus.Rs2D = 2;
      step();
      clear_inputs();
      step();
      hz_bus.ResultSrcE = 2'b01; hz_bus.RdE = 4; hz_bus.Rs1D = 4;
      step();
      clear_inputs();
      step();
      hz_bus.PCSrcE = 1;
      step();
      clear_inputs();
      cycle();
`ifdef PIPE_HAZARD_PERF_CNT_EN
      check("perf_stalls", hz_bus.StallCycles, 32'd2);
      check("perf_flushes", hz_bus.FlushCount, 32'd3);
`else
      check("perf_stalls_off", hz_bus.StallCycles, 32'd0);
      check("perf_flushes_off", hz_bus.FlushCount, 32'd0);
`endif
      advance();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset             = ($urandom_range(0, 49) == 0);
         hz_bus.Rs1D       = 5'($urandom_range(0, 3));
         hz_bus.Rs2D       = 5'($urandom_range(0, 3));
         hz_bus.Rs1E       = 5'($urandom_range(0, 3));
         hz_bus.Rs2E       = 5'($urandom_range(0, 3));
         hz_bus.RdE        = 5'($urandom_range(0, 3));
         hz_bus.RdM        = 5'($urandom_range(0, 3));
         hz_bus.RdW        = 5'($urandom_range(0, 3));
         hz_bus.ResultSrcE = 2'($urandom_range(0, 3));
         hz_bus.RegWriteM  = 1'($urandom_range(0, 1));
         hz_bus.RegWriteW  = 1'($urandom_range(0, 1));
         hz_bus.PCSrcE     = ($urandom_range(0, 3) == 0);
         hz_bus.MemAccessM = ($urandom_range(0, 2) == 0);
         hz_bus.MemAckM    = 1'($urandom_range(0, 1));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
